sub_bytes_engine: RTL

Multi-cycle, parametrised AES SubBytes unit. It substitutes an NB-bit state through the AES S-box at LANES bytes per clock, and optionally through the inverse S-box.
Sits between the round-key adder and ShiftRows in the iterative AES datapath. It trades area against latency and uses valid/ready handshakes on both sides.

---
 rtl/sub_bytes_engine_pkg.sv | 18 +
 rtl/sub_bytes_engine_if.sv | 22 ++
 rtl/aes_defs.vh | 51 +++++
 rtl/sbox_byte.sv | 22 ++
 rtl/sub_bytes_engine.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/sub_bytes_engine_pkg.sv
// Package for the SubBytes engine: pulls in the shared AES constants and
// defines the FSM state type plus a small width helper.
package sub_bytes_engine_pkg;

`include "aes_defs.vh"

    typedef enum logic [1:0] {
        ST_IDLE = AES_ST_IDLE,
        ST_BUSY = AES_ST_BUSY,
        ST_DONE = AES_ST_DONE
    } state_e;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sub_bytes_engine_if.sv
// Valid/ready block interface of the SubBytes engine (input and output side).
interface sub_bytes_engine_if #(
    parameter int NB = 128
) ();
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] in_data;
    logic          in_inv;
    logic          out_valid;
    logic          out_ready;
    logic [NB-1:0] out_data;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_defs.vh
// Shared AES constants: byte width, default state width, FSM encodings and
// the FIPS-197 forward/inverse S-box tables (byte 0x00 entry in the MSBs).
`ifndef AES_DEFS_VH
`define AES_DEFS_VH

localparam int AES_BYTE_W     = 8;
localparam int AES_NB_DEFAULT = 128;

localparam logic [1:0] AES_ST_IDLE = 2'd0;
localparam logic [1:0] AES_ST_BUSY = 2'd1;
localparam logic [1:0] AES_ST_DONE = 2'd2;

localparam logic [2047:0] AES_SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
};

localparam logic [2047:0] AES_SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
};

`endif

// File: rtl/sbox_byte.sv
// One combinational AES S-box lane. The inverse table and the inv select
// exist only when SBOX_INVERSE_EN is defined.
module sbox_byte
    import sub_bytes_engine_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] din,
`ifdef SBOX_INVERSE_EN
    input  logic                  inv,
`endif
    output logic [AES_BYTE_W-1:0] dout
);
    // Entry 0 sits in the MSBs, so the bit offset is (255 - din) * 8 = {~din, 3'b000}.
    logic [10:0] pos_s;

    assign pos_s = {~din, 3'b000};

`ifdef SBOX_INVERSE_EN
    assign dout = inv ? AES_SBOX_INV[pos_s +: AES_BYTE_W] : AES_SBOX_FWD[pos_s +: AES_BYTE_W];
`else
    assign dout = AES_SBOX_FWD[pos_s +: AES_BYTE_W];
`endif
endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes: LANES bytes per clock over BEATS cycles, valid/ready
// on both sides. Define SBOX_INVERSE_EN to add the inverse S-box selected by in_inv.
module sub_bytes_engine
    import sub_bytes_engine_pkg::*;
#(
    parameter int NB    = AES_NB_DEFAULT,
    parameter int LANES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sub_bytes_engine_if.slave bus,
    output logic              busy
);
    localparam int NBYTES = NB / AES_BYTE_W;
    localparam int BEATS  = NBYTES / LANES;
    localparam int CNT_W  = clog2_min1(BEATS);
    localparam int BI_W   = clog2_min1(NBYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    if (((NB % AES_BYTE_W) != 0) || ((NBYTES % LANES) != 0)) begin : g_illegal_params
        sub_bytes_engine_illegal_parameters u_illegal ();
    end

    state_e                  state_r;
    state_e                  state_next_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [NB-1:0]           data_r;
    logic [NB-1:0]           data_sub_s;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    busy_r;
    logic                    in_ready_d_s;
    logic                    out_valid_d_s;
    logic                    busy_d_s;
    logic                    accept_s;
    logic                    release_s;
    logic                    last_beat_s;
    logic [AES_BYTE_W-1:0]   byte_s     [NBYTES];
    logic [AES_BYTE_W-1:0]   lane_in_s  [LANES];
    logic [AES_BYTE_W-1:0]   lane_out_s [LANES];
`ifdef SBOX_INVERSE_EN
    logic                    inv_r;
`else
    logic                    unused_inv_s;
    assign unused_inv_s = bus.in_inv;
`endif

    assign accept_s    = bus.in_valid && in_ready_r;
    assign release_s   = bus.out_ready && out_valid_r;
    assign last_beat_s = (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_BUSY;
                else          state_next_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (last_beat_s) state_next_s = ST_DONE;
                else             state_next_s = ST_BUSY;
            end
            ST_DONE: begin
                if (release_s) state_next_s = ST_IDLE;
                else           state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state; flopped below so no input reaches an output combinationally.
    always_comb begin
        in_ready_d_s  = 1'b0;
        out_valid_d_s = 1'b0;
        busy_d_s      = 1'b0;
        case (state_next_s)
            ST_IDLE: in_ready_d_s = 1'b1;
            ST_BUSY: busy_d_s     = 1'b1;
            ST_DONE: begin
                out_valid_d_s = 1'b1;
                busy_d_s      = 1'b1;
            end
            default: begin
                in_ready_d_s  = 1'b0;
                out_valid_d_s = 1'b0;
                busy_d_s      = 1'b0;
            end
        endcase
    end

    // Handshake/status output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_d_s;
            out_valid_r <= out_valid_d_s;
            busy_r      <= busy_d_s;
        end
    end

    // Block capture and per-beat substitution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            cnt_r  <= '0;
`ifdef SBOX_INVERSE_EN
            inv_r  <= 1'b0;
`endif
        end else if (accept_s) begin
            data_r <= bus.in_data;
            cnt_r  <= '0;
`ifdef SBOX_INVERSE_EN
            inv_r  <= bus.in_inv;
`endif
        end else if (state_r == ST_BUSY) begin
            data_r <= data_sub_s;
            cnt_r  <= cnt_r + CNT_W'(1);
        end
    end

    // Byte j (MSB first) takes its lane's result only during beat j / LANES.
    for (genvar j = 0; j < NBYTES; j++) begin : g_byte
        assign byte_s[j] = data_r[NB-AES_BYTE_W-AES_BYTE_W*j +: AES_BYTE_W];
        assign data_sub_s[NB-AES_BYTE_W-AES_BYTE_W*j +: AES_BYTE_W] =
            (cnt_r == CNT_W'(j / LANES)) ? lane_out_s[j % LANES] : byte_s[j];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [BI_W-1:0] idx_s;
        assign idx_s        = BI_W'(int'(cnt_r) * LANES + l);
        assign lane_in_s[l] = byte_s[idx_s];

        sbox_byte u_sbox (
            .din  (lane_in_s[l]),
`ifdef SBOX_INVERSE_EN
            .inv  (inv_r),
`endif
            .dout (lane_out_s[l])
        );
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = data_r;
    assign busy          = busy_r;
endmodule
